// File: rtl/dport_stream_checker_if.sv
// dport_stream_checker_if: control, expected-memory load, data-port and status signals of the stream checker
interface dport_stream_checker_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  parameter int CNT_W  = 32
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int LEN_W  = ADDR_W + 1;
  logic              start;
  logic              exp_we;
  logic [ADDR_W-1:0] exp_addr;
  logic [DATA_W-1:0] exp_data;
  logic [LEN_W-1:0]  exp_len;
  logic [DATA_W-1:0] dport_out;
  logic              dport_write;
  logic              done;
  logic              busy;
  logic              pass;
  logic              fail;
  logic              timeout;
  logic [1:0]        err_code;
  logic [LEN_W-1:0]  err_idx;
  logic [DATA_W-1:0] err_exp;
  logic [DATA_W-1:0] err_got;
  logic [CNT_W-1:0]  cycle_count;
  logic [LEN_W-1:0]  write_count;
  modport master (
    output start, exp_we, exp_addr, exp_data, exp_len, dport_out, dport_write, done,
    input  busy, pass, fail, timeout, err_code, err_idx, err_exp, err_got, cycle_count, write_count
  );
  modport slave (
    input  start, exp_we, exp_addr, exp_data, exp_len, dport_out, dport_write, done,
    output busy, pass, fail, timeout, err_code, err_idx, err_exp, err_got, cycle_count, write_count
  );
endinterface

// File: rtl/dport_stream_checker.sv
// dport_stream_checker: compares data-port beats against a preloaded expected stream with a cycle budget
module dport_stream_checker #(
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 256,
  parameter int MAX_CYCLES = 10000,
  parameter int CNT_W      = 32,
  parameter bit FAIL_FAST  = 1'b1
) (
  input logic                   clk,
  input logic                   rst,
  dport_stream_checker_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int LEN_W  = ADDR_W + 1;
  typedef enum logic [2:0] {S_IDLE, S_RUN, S_PASS, S_FAIL, S_TIMEOUT} state_t;
  state_t            r_state, w_state_n;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [LEN_W-1:0]  r_len, r_wcnt, w_wcnt_n, r_err_idx, w_idx_n;
  logic [CNT_W-1:0]  r_ccnt, w_ccnt_n;
  logic [1:0]        r_err_code, w_code_n;
  logic [DATA_W-1:0] r_err_exp, w_eexp_n, r_err_got, w_egot_n, w_exp;
  logic              w_to, w_ovf, w_mis, w_err, w_has_err;
  assign w_exp     = r_mem[r_wcnt[ADDR_W-1:0]];
  assign w_to      = r_ccnt == CNT_W'(MAX_CYCLES);
  assign w_ovf     = bus.dport_write && r_wcnt == LEN_W'(DEPTH);
  assign w_mis     = bus.dport_write && !w_ovf && bus.dport_out != w_exp;
  assign w_err     = w_ovf || w_mis;
  assign w_has_err = r_err_code != 2'd0;
  always_ff @(posedge clk)
    if (bus.exp_we && r_state != S_RUN) r_mem[bus.exp_addr] <= bus.exp_data;
  always_comb begin
    w_state_n = r_state;
    w_wcnt_n  = r_wcnt;
    w_ccnt_n  = r_ccnt;
    w_code_n  = r_err_code;
    w_idx_n   = r_err_idx;
    w_eexp_n  = r_err_exp;
    w_egot_n  = r_err_got;
    if (r_state != S_RUN) begin
      if (bus.start) begin
        w_state_n = S_RUN;
        w_wcnt_n  = '0;
        w_ccnt_n  = '0;
        w_code_n  = 2'd0;
        w_idx_n   = '0;
        w_eexp_n  = '0;
        w_egot_n  = '0;
      end
    end else if (w_to) begin
      w_state_n = S_TIMEOUT;
    end else begin
      w_ccnt_n = r_ccnt + CNT_W'(~&r_ccnt);
      if (bus.dport_write && !w_ovf) w_wcnt_n = r_wcnt + LEN_W'(1);
      if (w_err && !w_has_err) begin
        w_code_n = w_ovf ? 2'd3 : 2'd1;
        w_idx_n  = r_wcnt;
        w_eexp_n = w_ovf ? '0 : w_exp;
        w_egot_n = bus.dport_out;
      end
      // done sees the count after this cycle's beat
      if (bus.done) begin
        if (w_err || w_has_err) w_state_n = S_FAIL;
        else if (w_wcnt_n != r_len) begin
          w_state_n = S_FAIL;
          w_code_n  = 2'd2;
          w_idx_n   = w_wcnt_n;
          w_eexp_n  = '0;
          w_egot_n  = '0;
        end else w_state_n = S_PASS;
      end else if (FAIL_FAST && (w_err || w_has_err)) w_state_n = S_FAIL;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_wcnt     <= '0;
      r_ccnt     <= '0;
      r_err_code <= 2'd0;
      r_err_idx  <= '0;
      r_err_exp  <= '0;
      r_err_got  <= '0;
    end else begin
      r_state    <= w_state_n;
      r_len      <= (r_state != S_RUN && bus.start) ? bus.exp_len : r_len;
      r_wcnt     <= w_wcnt_n;
      r_ccnt     <= w_ccnt_n;
      r_err_code <= w_code_n;
      r_err_idx  <= w_idx_n;
      r_err_exp  <= w_eexp_n;
      r_err_got  <= w_egot_n;
    end
  end
  assign bus.busy        = r_state == S_RUN;
  assign bus.pass        = r_state == S_PASS;
  assign bus.fail        = r_state == S_FAIL;
  assign bus.timeout     = r_state == S_TIMEOUT;
  assign bus.err_code    = r_err_code;
  assign bus.err_idx     = r_err_idx;
  assign bus.err_exp     = r_err_exp;
  assign bus.err_got     = r_err_got;
  assign bus.cycle_count = r_ccnt;
  assign bus.write_count = r_wcnt;
endmodule
